// File: rtl/drum_step_sequencer_if.sv
// Pattern-memory write bus between the control register block and the sequencer.
// The master side drives one step's voice-enable bits per strobe.
interface drum_step_sequencer_if #(
   parameter int STEPS  = 16,
   parameter int VOICES = 4
) ();
   localparam int SW = $clog2(STEPS);

   logic              pat_we;
   logic [SW-1:0]     pat_addr;
   logic [VOICES-1:0] pat_wdata;

   modport master (
      output pat_we,
      output pat_addr,
      output pat_wdata
   );

   modport slave (
      input pat_we,
      input pat_addr,
      input pat_wdata
   );
endinterface

// File: rtl/drum_step_sequencer.sv
// Tempo-driven STEPS x VOICES drum step sequencer with busy-voice drop counting.
// Define SEQ_SWING_EN to add the swing input (even/odd step spacing P+S / P-S).
module drum_step_sequencer #(
   parameter int STEPS   = 16,
   parameter int VOICES  = 4,
   parameter int TEMPO_W = 16
) (
   input  logic                       clk_rx,
   input  logic                       nrst,
   input  logic                       run,
   input  logic [TEMPO_W-1:0]         tempo_div,
`ifdef SEQ_SWING_EN
   input  logic [TEMPO_W-1:0]         swing,
`endif
   input  logic [$clog2(STEPS)-1:0]   pat_len,
   drum_step_sequencer_if.slave       pat,
   input  logic [VOICES-1:0]          voice_busy,
   output logic [VOICES-1:0]          trig,
   output logic [$clog2(STEPS)-1:0]   step_idx,
   output logic                       step_strobe,
   output logic [7:0]                 drop_cnt
);
   localparam int SW = $clog2(STEPS);
   localparam int CW = TEMPO_W + 1;

   typedef enum logic [1:0] {IDLE, FIRE, COUNT} state_t;

   state_t            state_q, state_d;
   logic [VOICES-1:0] pattern_q [STEPS];
   logic [SW-1:0]     idx_q, idx_next;
   logic [CW-1:0]     cnt_q, ivl_q, ivl_d;
   logic [7:0]        drop_q;
   logic [8:0]        miss_n, drop_sum;
   logic [VOICES-1:0] hit, miss;
   logic [TEMPO_W-1:0] p_clamp;
   logic              term, wrap;

   assign p_clamp = (tempo_div < TEMPO_W'(4)) ? TEMPO_W'(4) : tempo_div;

   // Interval to the next FIRE is latched whole, so P and S change together.
`ifdef SEQ_SWING_EN
   logic [TEMPO_W-1:0] s_max, s_val;
   assign s_max = (p_clamp >> 1) - TEMPO_W'(1);
   assign s_val = (swing < s_max) ? swing : s_max;
   assign ivl_d = idx_q[0] ? ({1'b0, p_clamp} - {1'b0, s_val})
                           : ({1'b0, p_clamp} + {1'b0, s_val});
`else
   assign ivl_d = {1'b0, p_clamp};
`endif

   assign term     = (cnt_q == ivl_q - CW'(2));
   assign wrap     = (idx_q >= pat_len) || (idx_q == SW'(STEPS - 1));
   assign idx_next = wrap ? '0 : idx_q + SW'(1);

   assign step_strobe = (state_q == FIRE);
   assign hit         = step_strobe ? pattern_q[idx_q] : '0;
   assign trig        = hit & ~voice_busy;
   assign miss        = hit & voice_busy;
   assign step_idx    = idx_q;
   assign drop_cnt    = drop_q;

   always_comb begin
      miss_n = '0;
      for (int v = 0; v < VOICES; v++)
         miss_n = miss_n + 9'(miss[v]);
      drop_sum = {1'b0, drop_q} + miss_n;
   end

   always_ff @(posedge clk_rx or negedge nrst) begin
      if (!nrst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // A low run wins over the terminal count in the same cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (run) state_d = FIRE;
         FIRE:    state_d = run ? COUNT : IDLE;
         COUNT: begin
            if (!run)
               state_d = IDLE;
            else if (term)
               state_d = FIRE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_rx or negedge nrst) begin
      if (!nrst) begin
         idx_q  <= '0;
         cnt_q  <= '0;
         ivl_q  <= CW'(4);
         drop_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               idx_q <= '0;
               cnt_q <= '0;
            end
            FIRE: begin
               ivl_q  <= ivl_d;
               cnt_q  <= '0;
               drop_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
               if (!run)
                  idx_q <= '0;
            end
            COUNT: begin
               cnt_q <= cnt_q + CW'(1);
               if (!run)
                  idx_q <= '0;
               else if (term)
                  idx_q <= idx_next;
            end
            default: ;
         endcase
      end
   end

   // Reads during FIRE see the old word; a same-cycle write lands on the edge.
   always_ff @(posedge clk_rx or negedge nrst) begin
      if (!nrst) begin
         for (int s = 0; s < STEPS; s++)
            pattern_q[s] <= '0;
      end else if (pat.pat_we) begin
         pattern_q[pat.pat_addr] <= pat.pat_wdata;
      end
   end
endmodule
